// File: rtl/pcie_tl_tx_arbiter.sv
// REQ/CPL TLP transmit arbiter: packet-granular round robin (strict CPL priority under TX_ARB_CPL_PRIORITY_EN),
// header credits taken at grant, 1-cycle grant-to-first-beat, SEND is a combinational pass-through that stalls on tx_ready.
module pcie_tl_tx_arbiter #(
  parameter int DATA_WIDTH       = 256,
  parameter int HDR_WIDTH        = 128,
  parameter int CREDIT_WIDTH     = 8,
  parameter int REQ_INIT_CREDITS = 16,
  parameter int CPL_INIT_CREDITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [HDR_WIDTH-1:0]    req_header,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic                    req_sop,
  input  logic                    req_eop,
  output logic                    req_ready,
  input  logic                    cpl_valid,
  input  logic [HDR_WIDTH-1:0]    cpl_header,
  input  logic [DATA_WIDTH-1:0]   cpl_data,
  input  logic                    cpl_sop,
  input  logic                    cpl_eop,
  output logic                    cpl_ready,
  output logic                    tx_valid,
  output logic [HDR_WIDTH-1:0]    tx_header,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_sop,
  output logic                    tx_eop,
  input  logic                    tx_ready,
  input  logic                    credit_ret_req,
  input  logic                    credit_ret_cpl,
  output logic [CREDIT_WIDTH-1:0] req_credits,
  output logic [CREDIT_WIDTH-1:0] cpl_credits,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, SEND_REQ, SEND_CPL} state_t;

  localparam logic LG_REQ = 1'b0;
  localparam logic LG_CPL = 1'b1;
  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = '1;
  localparam logic [CREDIT_WIDTH-1:0] CRED_ONE = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CREDIT_WIDTH-1:0] REQ_INIT = CREDIT_WIDTH'(REQ_INIT_CREDITS);
  localparam logic [CREDIT_WIDTH-1:0] CPL_INIT = CREDIT_WIDTH'(CPL_INIT_CREDITS);

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [CREDIT_WIDTH-1:0] req_cred_q, req_cred_d;
  logic [CREDIT_WIDTH-1:0] cpl_cred_q, cpl_cred_d;
  logic                    req_elig, cpl_elig, grant_req, grant_cpl;

  // Consume and return in the same cycle cancel; returns beyond the counter range are dropped.
  function automatic logic [CREDIT_WIDTH-1:0] next_credit(
    input logic [CREDIT_WIDTH-1:0] cur,
    input logic                    consume,
    input logic                    ret
  );
    logic [CREDIT_WIDTH-1:0] nxt;
    nxt = cur;
    if (consume && !ret)
      nxt = cur - CRED_ONE;
    else if (!consume && ret && (cur != CRED_MAX))
      nxt = cur + CRED_ONE;
    return nxt;
  endfunction

  always_comb begin
    req_elig  = req_valid && req_sop && (req_cred_q != '0);
    cpl_elig  = cpl_valid && cpl_sop && (cpl_cred_q != '0);
    grant_req = 1'b0;
    grant_cpl = 1'b0;
    if (state_q == IDLE) begin
`ifdef TX_ARB_CPL_PRIORITY_EN
      grant_cpl = cpl_elig;
      grant_req = req_elig && !cpl_elig;
`else
      if (req_elig && cpl_elig) begin
        grant_req = (last_grant_q == LG_CPL);
        grant_cpl = (last_grant_q == LG_REQ);
      end else begin
        grant_req = req_elig;
        grant_cpl = cpl_elig;
      end
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tx_valid     = 1'b0;
    tx_header    = '0;
    tx_data      = '0;
    tx_sop       = 1'b0;
    tx_eop       = 1'b0;
    req_ready    = 1'b0;
    cpl_ready    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_req) begin
          state_d      = SEND_REQ;
          last_grant_d = LG_REQ;
        end else if (grant_cpl) begin
          state_d      = SEND_CPL;
          last_grant_d = LG_CPL;
        end
      end
      SEND_REQ: begin
        busy      = 1'b1;
        tx_valid  = req_valid;
        tx_header = req_header;
        tx_data   = req_data;
        tx_sop    = req_sop;
        tx_eop    = req_eop;
        req_ready = tx_ready;
        if (req_valid && tx_ready && req_eop)
          state_d = IDLE;
      end
      SEND_CPL: begin
        busy      = 1'b1;
        tx_valid  = cpl_valid;
        tx_header = cpl_header;
        tx_data   = cpl_data;
        tx_sop    = cpl_sop;
        tx_eop    = cpl_eop;
        cpl_ready = tx_ready;
        if (cpl_valid && tx_ready && cpl_eop)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_cred_d = next_credit(req_cred_q, grant_req, credit_ret_req);
    cpl_cred_d = next_credit(cpl_cred_q, grant_cpl, credit_ret_cpl);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LG_CPL;
      req_cred_q   <= REQ_INIT;
      cpl_cred_q   <= CPL_INIT;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_cred_q   <= req_cred_d;
      cpl_cred_q   <= cpl_cred_d;
    end
  end

  assign req_credits = req_cred_q;
  assign cpl_credits = cpl_cred_q;

endmodule

// File: tb/tb_pcie_tl_tx_arbiter.sv
// Bench for pcie_tl_tx_arbiter: directed scenarios then random traffic, all checked against a packet-level reference model.
module tb_pcie_tl_tx_arbiter;

  localparam int DW = 256;
  localparam int HW = 128;
  localparam int CW = 8;
  localparam int INIT = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          req_valid, req_sop, req_eop, req_ready;
  logic [HW-1:0] req_header;
  logic [DW-1:0] req_data;
  logic          cpl_valid, cpl_sop, cpl_eop, cpl_ready;
  logic [HW-1:0] cpl_header;
  logic [DW-1:0] cpl_data;
  logic          tx_valid, tx_sop, tx_eop, tx_ready;
  logic [HW-1:0] tx_header;
  logic [DW-1:0] tx_data;
  logic          credit_ret_req, credit_ret_cpl, busy;
  logic [CW-1:0] req_credits, cpl_credits;

  pcie_tl_tx_arbiter #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .CREDIT_WIDTH(CW),
    .REQ_INIT_CREDITS(INIT), .CPL_INIT_CREDITS(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_header(req_header), .req_data(req_data),
    .req_sop(req_sop), .req_eop(req_eop), .req_ready(req_ready),
    .cpl_valid(cpl_valid), .cpl_header(cpl_header), .cpl_data(cpl_data),
    .cpl_sop(cpl_sop), .cpl_eop(cpl_eop), .cpl_ready(cpl_ready),
    .tx_valid(tx_valid), .tx_header(tx_header), .tx_data(tx_data),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_ready(tx_ready),
    .credit_ret_req(credit_ret_req), .credit_ret_cpl(credit_ret_cpl),
    .req_credits(req_credits), .cpl_credits(cpl_credits), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Source beat queues (index 0 is the beat currently presented).
  logic [DW-1:0] rq_d[$], cq_d[$];
  logic [HW-1:0] rq_h[$], cq_h[$];
  logic          rq_s[$], cq_s[$], rq_e[$], cq_e[$];

  // Packet-level model: which source owns the link, who won last, credit balances.
  int m_own;   // 0 none, 1 REQ, 2 CPL
  int m_last;  // 1 REQ, 2 CPL
  int m_cr[2];

  // Log of every beat the DLL accepted.
  int acc_src[$];
  int acc_cyc[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_last = 2; m_cr[0] = INIT; m_cr[1] = INIT;
    rq_d.delete(); rq_h.delete(); rq_s.delete(); rq_e.delete();
    cq_d.delete(); cq_h.delete(); cq_s.delete(); cq_e.delete();
  endtask

  task automatic push_pkt(input int src, input int len, input bit bad_sop);
    logic [DW-1:0] d;
    logic [HW-1:0] h;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      for (int k = 0; k < HW / 32; k++) h[k*32 +: 32] = $urandom;
      if (src == 1) begin
        rq_d.push_back(d); rq_h.push_back(h);
        rq_s.push_back((i == 0) && !bad_sop); rq_e.push_back(i == len - 1);
      end else begin
        cq_d.push_back(d); cq_h.push_back(h);
        cq_s.push_back((i == 0) && !bad_sop); cq_e.push_back(i == len - 1);
      end
    end
  endtask

  task automatic drive();
    req_valid = (rq_d.size() != 0);
    req_data = '0; req_header = '0; req_sop = 1'b0; req_eop = 1'b0;
    if (req_valid) begin
      req_data = rq_d[0]; req_header = rq_h[0]; req_sop = rq_s[0]; req_eop = rq_e[0];
    end
    cpl_valid = (cq_d.size() != 0);
    cpl_data = '0; cpl_header = '0; cpl_sop = 1'b0; cpl_eop = 1'b0;
    if (cpl_valid) begin
      cpl_data = cq_d[0]; cpl_header = cq_h[0]; cpl_sop = cq_s[0]; cpl_eop = cq_e[0];
    end
  endtask

  // One clock: check outputs at negedge against the model, then advance the model over the posedge.
  task automatic step();
    int g;
    bit re, ce, ev, acc, last_beat;
    logic [DW-1:0] ed;
    logic [HW-1:0] eh;
    logic es, ee;
    drive();
    @(negedge clk);
    ev = 1'b0; ed = '0; eh = '0; es = 1'b0; ee = 1'b0;
    if (m_own == 1) begin ev = req_valid; ed = req_data; eh = req_header; es = req_sop; ee = req_eop; end
    if (m_own == 2) begin ev = cpl_valid; ed = cpl_data; eh = cpl_header; es = cpl_sop; ee = cpl_eop; end
    chk("tx_valid", 256'(tx_valid), 256'(ev));
    chk("req_ready", 256'(req_ready), 256'((m_own == 1) && tx_ready));
    chk("cpl_ready", 256'(cpl_ready), 256'((m_own == 2) && tx_ready));
    chk("busy", 256'(busy), 256'(m_own != 0));
    chk("req_credits", 256'(req_credits), 256'(m_cr[0]));
    chk("cpl_credits", 256'(cpl_credits), 256'(m_cr[1]));
    if (m_own != 0) begin
      chk("tx_data", 256'(tx_data), 256'(ed));
      chk("tx_header", 256'(tx_header), 256'(eh));
      chk("tx_sop", 256'(tx_sop), 256'(es));
      chk("tx_eop", 256'(tx_eop), 256'(ee));
    end else begin
      chk("idle_sop_eop", 256'({tx_sop, tx_eop}), 256'(0));
      chk("idle_no_x", 256'($isunknown(tx_data) || $isunknown(tx_header)), 256'(0));
    end
    re = req_valid && req_sop && (m_cr[0] != 0);
    ce = cpl_valid && cpl_sop && (m_cr[1] != 0);
    g = 0;
    if (m_own == 0) begin
`ifdef TX_ARB_CPL_PRIORITY_EN
      if (ce) g = 2; else if (re) g = 1;
`else
      if (re && ce) g = (m_last == 2) ? 1 : 2;
      else if (re) g = 1;
      else if (ce) g = 2;
`endif
    end
    acc = ev && tx_ready;
    if (acc) begin
      acc_src.push_back(m_own);
      acc_cyc.push_back(cyc);
      if (m_own == 1) begin
        last_beat = rq_e[0];
        void'(rq_d.pop_front()); void'(rq_h.pop_front()); void'(rq_s.pop_front()); void'(rq_e.pop_front());
      end else begin
        last_beat = cq_e[0];
        void'(cq_d.pop_front()); void'(cq_h.pop_front()); void'(cq_s.pop_front()); void'(cq_e.pop_front());
      end
      if (last_beat) m_own = 0;
    end
    if (g != 0) begin
      m_own = g;
      m_last = g;
    end
    m_cr[0] = m_cr[0] - ((g == 1) ? 1 : 0) + (credit_ret_req ? 1 : 0);
    m_cr[1] = m_cr[1] - ((g == 2) ? 1 : 0) + (credit_ret_cpl ? 1 : 0);
    if (m_cr[0] > CMAX) m_cr[0] = CMAX;
    if (m_cr[1] > CMAX) m_cr[1] = CMAX;
    @(posedge clk);
    #1;
    credit_ret_req = 1'b0;
    credit_ret_cpl = 1'b0;
    cyc++;
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((rq_d.size() != 0 || cq_d.size() != 0 || m_own != 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 256'(rq_d.size() + cq_d.size() + m_own), 256'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    int c_save, n, eop_i;
    bit seen2;

    rst_n = 1'b0; tx_ready = 1'b0; credit_ret_req = 1'b0; credit_ret_cpl = 1'b0;
    model_reset();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values.
    chk("rst_tx_valid", 256'(tx_valid), 256'(0));
    chk("rst_tx_header", 256'(tx_header), 256'(0));
    chk("rst_tx_data", 256'(tx_data), 256'(0));
    chk("rst_readys", 256'({req_ready, cpl_ready, busy}), 256'(0));
    chk("rst_req_credits", 256'(req_credits), 256'(INIT));
    chk("rst_cpl_credits", 256'(cpl_credits), 256'(INIT));

    // Valid without sop in IDLE is held, never granted.
    push_pkt(1, 1, 1'b1);
    tx_ready = 1'b1;
    repeat (4) step();
    chk("nosop_held", 256'({busy, req_ready}), 256'(0));
    model_reset();

    // Both sources contending with single-beat packets.
`ifdef TX_ARB_CPL_PRIORITY_EN
    exp_order = '{2, 2, 1, 1};
`else
    exp_order = '{1, 2, 1, 2};
`endif
    acc_src.delete(); acc_cyc.delete();
    push_pkt(1, 1, 1'b0); push_pkt(1, 1, 1'b0);
    push_pkt(2, 1, 1'b0); push_pkt(2, 1, 1'b0);
    seen2 = 1'b0; n = 0;
    while ((rq_d.size() != 0 || cq_d.size() != 0 || m_own != 0) && n < 40) begin
      step();
      n++;
      if (acc_src.size() == 2 && !seen2) begin
        seen2 = 1'b1;
`ifdef TX_ARB_CPL_PRIORITY_EN
        chk("two_grants_req_cr", 256'(req_credits), 256'(16));
        chk("two_grants_cpl_cr", 256'(cpl_credits), 256'(14));
`else
        chk("two_grants_req_cr", 256'(req_credits), 256'(15));
        chk("two_grants_cpl_cr", 256'(cpl_credits), 256'(15));
`endif
      end
    end
    chk("order_len", 256'(acc_src.size()), 256'(4));
    if (acc_src.size() == 4)
      for (int i = 0; i < 4; i++) chk("grant_order", 256'(acc_src[i]), 256'(exp_order[i]));

    // Four-beat REQ packet; CPL shows up during beat 2 and must wait for eop plus one idle cycle.
    acc_src.delete(); acc_cyc.delete();
    push_pkt(1, 4, 1'b0);
    n = 0;
    while (acc_src.size() < 1 && n < 10) begin step(); n++; end
    push_pkt(2, 1, 1'b0);
    drain(30, "no_interleave_drain");
    chk("no_interleave_len", 256'(acc_src.size()), 256'(5));
    if (acc_src.size() == 5) begin
      for (int i = 0; i < 4; i++) chk("req_beats_src", 256'(acc_src[i]), 256'(1));
      for (int i = 0; i < 3; i++) chk("req_contiguous", 256'(acc_cyc[i+1] - acc_cyc[i]), 256'(1));
      chk("cpl_after_bubble", 256'(acc_cyc[4] - acc_cyc[3]), 256'(2));
      chk("cpl_src", 256'(acc_src[4]), 256'(2));
    end

    // Exhaust REQ credits: one packet more than the balance stays held until a credit returns.
    c_save = m_cr[0];
    for (int i = 0; i <= c_save; i++) push_pkt(1, 1, 1'b0);
    n = 0;
    while (rq_d.size() > 1 && n < 200) begin step(); n++; end
    repeat (4) step();
    chk("starved_credits", 256'(req_credits), 256'(0));
    chk("starved_held", 256'({busy, req_ready}), 256'(0));
    chk("starved_pending", 256'(rq_d.size()), 256'(1));
    credit_ret_req = 1'b1;
    step();
    step();
    chk("regrant_busy", 256'(busy), 256'(1));
    chk("regrant_credits", 256'(req_credits), 256'(0));
    drain(20, "regrant_drain");

    // Return coinciding with a CPL grant leaves the balance unchanged.
    c_save = m_cr[1];
    push_pkt(2, 1, 1'b0);
    credit_ret_cpl = 1'b1;
    step();
    chk("grant_and_return", 256'(cpl_credits), 256'(c_save));
    drain(10, "grant_return_drain");

    // 300 returns saturate both counters.
    for (int i = 0; i < 300; i++) begin
      credit_ret_req = 1'b1; credit_ret_cpl = 1'b1;
      step();
    end
    chk("sat_req", 256'(req_credits), 256'(CMAX));
    chk("sat_cpl", 256'(cpl_credits), 256'(CMAX));

    // tx_ready stalls inside a 3-beat CPL packet.
    acc_src.delete(); acc_cyc.delete();
    push_pkt(2, 3, 1'b0);
    tx_ready = 1'b1;
    step();
    foreach (exp_order[i]) exp_order[i] = 0;
    for (int i = 0; i < 5; i++) begin
      tx_ready = (i == 1 || i == 2) ? 1'b0 : 1'b1;
      step();
    end
    chk("stall_beats", 256'(acc_src.size()), 256'(3));
    chk("stall_idle_after", 256'(busy), 256'(0));
    eop_i = acc_src.size();
    if (eop_i == 3) chk("stall_spacing", 256'(acc_cyc[1] - acc_cyc[0]), 256'(3));

    // Asynchronous reset during beat 2 of a REQ packet.
    acc_src.delete(); acc_cyc.delete();
    push_pkt(1, 4, 1'b0);
    tx_ready = 1'b1;
    n = 0;
    while (acc_src.size() < 1 && n < 10) begin step(); n++; end
    chk("pre_reset_busy", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 256'(tx_valid), 256'(0));
    chk("arst_busy_ready", 256'({busy, req_ready}), 256'(0));
    chk("arst_req_cr", 256'(req_credits), 256'(INIT));
    chk("arst_cpl_cr", 256'(cpl_credits), 256'(INIT));
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (rq_d.size() == 0 && $urandom_range(0, 2) == 0) push_pkt(1, $urandom_range(1, 4), 1'b0);
      if (cq_d.size() == 0 && $urandom_range(0, 2) == 0) push_pkt(2, $urandom_range(1, 4), 1'b0);
      tx_ready = ($urandom_range(0, 3) != 0);
      credit_ret_req = ($urandom_range(0, 2) == 0);
      credit_ret_cpl = ($urandom_range(0, 2) == 0);
      step();
    end
    tx_ready = 1'b1;
    n = 0;
    while ((rq_d.size() != 0 || cq_d.size() != 0 || m_own != 0) && n < 600) begin
      credit_ret_req = ($urandom_range(0, 1) == 0);
      credit_ret_cpl = ($urandom_range(0, 1) == 0);
      step();
      n++;
    end
    chk("random_drained", 256'(rq_d.size() + cq_d.size() + m_own), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
